// File: rtl/fltc_pkg.sv
// Shared types and constants for the fault-report arbiter.
package fltc_pkg;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    IDLE     = 2'd1,
    REPORT   = 2'd2
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int RST_DLY_DEF = 16;

  function automatic int id_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fltc_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module fltc_rr_arb
  import fltc_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    first;
  logic [ID_W:0]      sum;

  // Rotating the doubled vector puts the request at ptr into bit 0.
  assign rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    first = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = ID_W'(i);
    end
  end

  assign sum       = {1'b0, ptr} + {1'b0, first};
  assign gnt_id    = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                 : sum[ID_W-1:0];
  assign gnt_valid = |req;

endmodule

// File: rtl/fltc_fault_arb.sv
// Collects fault pulses from NUM_REQ checkers and reports them one at a time.
//   state    | meaning
//   RST_WAIT | counting RST_DLY cycles after reset, faults ignored
//   IDLE     | pick next pending requester round-robin
//   REPORT   | hold rpt_id until downstream accepts
module fltc_fault_arb
  import fltc_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int RST_DLY = RST_DLY_DEF,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] fault_req,
  input  logic               clr,
  output logic               rpt_valid,
  output logic [ID_W-1:0]    rpt_id,
  input  logic               rpt_ready,
  output logic               observed_value,
  output logic               reset_n_delay,
  output logic [NUM_REQ-1:0] fault_sticky,
  output logic               overflow
);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    rpt_id_q, rpt_id_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] sticky_q, sticky_d;
  logic               overflow_q, overflow_d;
  logic               rst_dly_q, rst_dly_d;

  logic [NUM_REQ-1:0] acc;
  logic [NUM_REQ-1:0] done_mask;
  logic               hs;
  logic               ovf_set;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;

  fltc_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req       (pending_q),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    acc = (state_q == RST_WAIT) ? '0 : fault_req;
    hs  = (state_q == REPORT) && rpt_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      done_mask[i] = hs && (rpt_id_q == ID_W'(i));
    end
    // A request landing on the slot being retired re-arms it rather than overflowing.
    ovf_set    = |(acc & pending_q & ~done_mask);
    pending_d  = (pending_q & ~done_mask) | acc;
    sticky_d   = (clr ? '0 : sticky_q) | acc;
    overflow_d = (clr ? 1'b0 : overflow_q) | ovf_set;

    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    rpt_id_d  = rpt_id_q;
    rst_dly_d = rst_dly_q;

    case (state_q)
      RST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(RST_DLY - 1)) begin
          state_d   = IDLE;
          rst_dly_d = 1'b1;
        end
      end
      IDLE: begin
        if (gnt_valid) begin
          rpt_id_d = gnt_id;
          state_d  = REPORT;
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          ptr_d   = (rpt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rpt_id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_WAIT;
      cnt_q      <= '0;
      ptr_q      <= '0;
      rpt_id_q   <= '0;
      pending_q  <= '0;
      sticky_q   <= '0;
      overflow_q <= 1'b0;
      rst_dly_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rpt_id_q   <= rpt_id_d;
      pending_q  <= pending_d;
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
      rst_dly_q  <= rst_dly_d;
    end
  end

  assign rpt_valid      = (state_q == REPORT);
  assign rpt_id         = rpt_id_q;
  assign observed_value = |sticky_q;
  assign reset_n_delay  = rst_dly_q;
  assign fault_sticky   = sticky_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/fltc_fault_arb.md
FLTC_FAULT_ARB -- requirements
Module: fltc_fault_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of fault-checker requesters (2..32).
REQ-002 Parameter RST_DLY, default 16, cycles from reset release to reset_n_delay assertion (1..255).
REQ-003 Derived constant ID_W = max(1, $clog2(NUM_REQ)), width of requester index.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 fault_req  input  NUM_REQ  per-checker fault pulse, one bit per requester.
REQ-007 clr  input  1  synchronous clear of fault_sticky and overflow.
REQ-008 rpt_valid  output  1  fault report available.
REQ-009 rpt_id  output  ID_W  index of reported requester; stable while rpt_valid=1.
REQ-010 rpt_ready  input  1  downstream accepts report.
REQ-011 observed_value  output  1  OR-reduction of fault_sticky.
REQ-012 reset_n_delay  output  1  delayed, synchronously released reset indication.
REQ-013 fault_sticky  output  NUM_REQ  per-requester sticky fault flags.
REQ-014 overflow  output  1  sticky flag: fault lost because requester already pending.

Function
REQ-015 FSM states RST_WAIT, IDLE, REPORT; reset state RST_WAIT.
REQ-016 RST_WAIT: 8-bit counter increments each cycle; on reaching RST_DLY-1, next state IDLE and reset_n_delay=1 from the following cycle onward.
REQ-017 reset_n_delay rises exactly RST_DLY cycles after the first posedge with reset_n=1; it stays 1 until the next reset.
REQ-018 fault_req is ignored entirely while state=RST_WAIT.
REQ-019 Accepted fault_req[i] sets pending[i] and fault_sticky[i] at that edge (visible next cycle).
REQ-020 observed_value is combinational OR of fault_sticky; no extra latency.
REQ-021 IDLE with any pending bit: round-robin pick starting at pointer ptr; register rpt_id, go REPORT; rpt_valid=1 exactly when state=REPORT.
REQ-022 Latency: fault_req high in cycle N with empty pending and state IDLE -> rpt_valid=1 in cycle N+2.
REQ-023 REPORT: hold rpt_valid and rpt_id until rpt_valid & rpt_ready; at that edge clear pending[rpt_id], set ptr = (rpt_id+1) mod NUM_REQ, go IDLE.
REQ-024 Minimum one IDLE cycle between consecutive reports (max throughput one report per 2 cycles).
REQ-025 fault_req[i] while pending[i]=1 and not being cleared that cycle: set overflow; pending unchanged.
REQ-026 fault_req[i] in the same cycle as handshake on rpt_id=i: pending[i] remains 1, overflow not set.
REQ-027 clr clears fault_sticky and overflow only; pending, ptr, and in-flight report unaffected.
REQ-028 clr and fault_req[i] in same cycle: fault_sticky[i]=1 afterwards (set wins); same for overflow.
REQ-029 ptr wraps from NUM_REQ-1 to 0.

Reset
REQ-030 reset_n=0 asynchronously forces: state RST_WAIT, counter 0, ptr 0, pending 0, fault_sticky 0, overflow 0, rpt_id 0, rpt_valid 0, reset_n_delay 0, observed_value 0.
REQ-031 Reset mid-REPORT drops rpt_valid immediately, discards the report and all pending faults.

Structure
REQ-032 Package fltc_pkg holds FSM state enum, defaults for NUM_REQ/RST_DLY, and ID_W helper function.
REQ-033 Single sub-module fltc_rr_arb: combinational round-robin picker (inputs req vector, ptr; outputs gnt_valid, gnt_id).

Verification
REQ-034 Reset release, RST_DLY=16, fault_req pulsed cycles 0..15 -> reset_n_delay rises at cycle 16, no sticky/pending set.
REQ-035 fault_req=4'b0100 in cycle N, rpt_ready=1 -> rpt_valid at N+2, rpt_id=2, observed_value=1 at N+1.
REQ-036 fault_req=4'b1111 one cycle, ptr=0, rpt_ready=1 -> reports ids 0,1,2,3 in order, one per 2 cycles, then ptr=0.
REQ-037 rpt_ready=0, fault_req[1] pulsed twice -> overflow=1, single report id 1 once ready asserted.
REQ-038 fault_req[3] coincident with handshake of id 3 -> second report id 3 follows, overflow=0.
REQ-039 clr with fault_req[0] same cycle -> fault_sticky[0]=1, others 0; reset_n asserted during REPORT -> rpt_valid=0 same cycle.
